// File: rtl/pid_mc.sv
// pid_mc: time-multiplexed multi-channel PID controller.
// A single subtract/multiply/shift/add datapath is stepped through
// ERR -> MUL -> SHF -> ACC once per channel after a start request.
// Integrator and previous-error state are kept internally per channel.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, clear        run all channels once / zero per-channel state (IDLE only)
//   pos_d, pos          signed setpoints and measured positions, channel c at [c*W +: W]
//   kp_n, ki_n, kd_n    signed gain numerators per channel
//   kp_sh, ki_sh, kd_sh right-shift amounts per channel (denominator = 2^sh)
//   pwm, dir, sat       saturated output, ~sign(pwm), output-clamped flag per channel
//   err, int_err        last error and integrator per channel
//   busy, done          run in progress / one-cycle completion pulse
//
// Optional feature: define PID_ANTIWINDUP_EN to freeze the integrator on a
// run whose output clamps in the direction the error is pushing.
module pid_mc #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned W       = 13,
    parameter int unsigned SHW     = 4,
    parameter int unsigned INT_LIM = 2047
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic [NUM_CH*W-1:0]   pos_d,
    input  logic [NUM_CH*W-1:0]   pos,
    input  logic [NUM_CH*W-1:0]   kp_n,
    input  logic [NUM_CH*W-1:0]   ki_n,
    input  logic [NUM_CH*W-1:0]   kd_n,
    input  logic [NUM_CH*SHW-1:0] kp_sh,
    input  logic [NUM_CH*SHW-1:0] ki_sh,
    input  logic [NUM_CH*SHW-1:0] kd_sh,
    output logic [NUM_CH*W-1:0]   pwm,
    output logic [NUM_CH-1:0]     dir,
    output logic [NUM_CH*W-1:0]   err,
    output logic [NUM_CH*W-1:0]   int_err,
    output logic [NUM_CH-1:0]     sat,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned PW = 2 * W;

    typedef logic signed [W-1:0]  word_t;
    typedef logic signed [PW-1:0] prod_t;

    localparam prod_t MAX_W  = PW'((2 ** (W - 1)) - 1);
    localparam prod_t MIN_W  = -MAX_W - PW'(1);
    localparam prod_t ILIM_P = PW'(INT_LIM);
    localparam prod_t ILIM_N = -ILIM_P;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_MUL,
        S_SHF,
        S_ACC,
        S_DONE
    } state_t;

    // Saturate a wide signed value into the W-bit range.
    function automatic word_t sat_w(input prod_t x);
        if (x > MAX_W)      return word_t'(MAX_W[W-1:0]);
        else if (x < MIN_W) return word_t'(MIN_W[W-1:0]);
        else                return word_t'(x[W-1:0]);
    endfunction

    // Per-channel views of the packed buses
    word_t          pos_d_a [NUM_CH];
    word_t          pos_a   [NUM_CH];
    word_t          kp_a    [NUM_CH];
    word_t          ki_a    [NUM_CH];
    word_t          kd_a    [NUM_CH];
    logic [SHW-1:0] kps_a   [NUM_CH];
    logic [SHW-1:0] kis_a   [NUM_CH];
    logic [SHW-1:0] kds_a   [NUM_CH];

    // Output registers double as the stored previous error / integrator
    word_t pwm_a [NUM_CH];
    word_t err_a [NUM_CH];
    word_t int_a [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign pos_d_a[c] = pos_d[c*W +: W];
        assign pos_a[c]   = pos[c*W +: W];
        assign kp_a[c]    = kp_n[c*W +: W];
        assign ki_a[c]    = ki_n[c*W +: W];
        assign kd_a[c]    = kd_n[c*W +: W];
        assign kps_a[c]   = kp_sh[c*SHW +: SHW];
        assign kis_a[c]   = ki_sh[c*SHW +: SHW];
        assign kds_a[c]   = kd_sh[c*SHW +: SHW];
        assign pwm[c*W +: W]     = pwm_a[c];
        assign err[c*W +: W]     = err_a[c];
        assign int_err[c*W +: W] = int_a[c];
    end

    state_t         state;
    logic [CW-1:0]  idx;

    // Pipeline registers between datapath stages
    word_t          e_r, i_r, d_r;
    word_t          kp_r, ki_r, kd_r;
    logic [SHW-1:0] sp_r, si_r, sd_r;
    prod_t          p_p, p_i, p_d;
    word_t          t_p, t_i, t_d;

    // ERR-stage arithmetic for the current channel
    prod_t isum_c;
    word_t e_c, i_c, d_c;
    always_comb begin
        e_c    = sat_w(PW'(pos_d_a[idx]) - PW'(pos_a[idx]));
        isum_c = PW'(int_a[idx]) + PW'(e_c);
        if (isum_c > ILIM_P)      i_c = word_t'(ILIM_P[W-1:0]);
        else if (isum_c < ILIM_N) i_c = word_t'(ILIM_N[W-1:0]);
        else                      i_c = word_t'(isum_c[W-1:0]);
        d_c    = sat_w(PW'(e_c) - PW'(err_a[idx]));
    end

    // ACC-stage sum (value fits W+2 bits) and output clamp
    prod_t sum_c;
    word_t pwm_c;
    logic  clamp_c;
    logic  hold_c;
    always_comb begin
        sum_c   = PW'(t_p) + PW'(t_i) + PW'(t_d);
        pwm_c   = sat_w(sum_c);
        clamp_c = (sum_c > MAX_W) || (sum_c < MIN_W);
    end

`ifdef PID_ANTIWINDUP_EN
    // Freeze the integrator when the clamp is in the direction of the error
    assign hold_c = clamp_c && (e_r[W-1] == sum_c[PW-1]);
`else
    assign hold_c = 1'b0;
`endif

    // Sequencer and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dir   <= '1;
            sat   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pwm_a[c] <= '0;
                err_a[c] <= '0;
                int_a[c] <= '0;
            end
            e_r  <= '0;
            i_r  <= '0;
            d_r  <= '0;
            kp_r <= '0;
            ki_r <= '0;
            kd_r <= '0;
            sp_r <= '0;
            si_r <= '0;
            sd_r <= '0;
            p_p  <= '0;
            p_i  <= '0;
            p_d  <= '0;
            t_p  <= '0;
            t_i  <= '0;
            t_d  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            err_a[c] <= '0;
                            int_a[c] <= '0;
                        end
                    end
                    if (start) begin
                        state <= S_ERR;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_ERR: begin
                    e_r   <= e_c;
                    i_r   <= i_c;
                    d_r   <= d_c;
                    kp_r  <= kp_a[idx];
                    ki_r  <= ki_a[idx];
                    kd_r  <= kd_a[idx];
                    sp_r  <= kps_a[idx];
                    si_r  <= kis_a[idx];
                    sd_r  <= kds_a[idx];
                    state <= S_MUL;
                end
                S_MUL: begin
                    p_p   <= PW'(kp_r) * PW'(e_r);
                    p_i   <= PW'(ki_r) * PW'(i_r);
                    p_d   <= PW'(kd_r) * PW'(d_r);
                    state <= S_SHF;
                end
                S_SHF: begin
                    t_p   <= sat_w(p_p >>> sp_r);
                    t_i   <= sat_w(p_i >>> si_r);
                    t_d   <= sat_w(p_d >>> sd_r);
                    state <= S_ACC;
                end
                S_ACC: begin
                    pwm_a[idx] <= pwm_c;
                    dir[idx]   <= ~pwm_c[W-1];
                    sat[idx]   <= clamp_c;
                    err_a[idx] <= e_r;
                    if (!hold_c) begin
                        int_a[idx] <= i_r;
                    end
                    if (idx == CW'(NUM_CH - 1)) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + CW'(1);
                        state <= S_ERR;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_mc.sv
// Directed bench for pid_mc (NUM_CH=2, W=13): table of per-run vectors on
// channel 0 with channel 1 held at a fixed P-only setting, followed by
// hand-written sequences for latency, start-while-busy and reset mid-run.
module tb_pid_mc;

    localparam int NCH = 2;
    localparam int DW  = 13;
    localparam int SW  = 4;
`ifdef PID_ANTIWINDUP_EN
    localparam int AW = 1;
`else
    localparam int AW = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                clear = 1'b0;
    logic [NCH*DW-1:0]   pos_d = '0, pos = '0, kp_n = '0, ki_n = '0, kd_n = '0;
    logic [NCH*SW-1:0]   kp_sh = '0, ki_sh = '0, kd_sh = '0;
    logic [NCH*DW-1:0]   pwm, err, int_err;
    logic [NCH-1:0]      dir, sat;
    logic                busy, done;

    int vectors = 0;
    int miscompares = 0;

    pid_mc #(.NUM_CH(NCH), .W(DW), .SHW(SW), .INT_LIM(2047)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .pos_d(pos_d), .pos(pos), .kp_n(kp_n), .ki_n(ki_n), .kd_n(kd_n),
        .kp_sh(kp_sh), .ki_sh(ki_sh), .kd_sh(kd_sh),
        .pwm(pwm), .dir(dir), .err(err), .int_err(int_err),
        .sat(sat), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit clr;
        int pd, p, kp, kps, ki, kis, kd, kds;
        int x_pwm, x_err, x_int, x_sat;
    } vec_t;

    vec_t tbl [14];

    function automatic int chv(input logic [NCH*DW-1:0] bus, input int c);
        logic [DW-1:0] s;
        s = bus[c*DW +: DW];
        return int'($signed(s));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Channel 1 stays at kp=1, e=-5 throughout
    task automatic set_ch0(input vec_t v);
        pos_d = {13'(-5), 13'(v.pd)};
        pos   = {13'd0, 13'(v.p)};
        kp_n  = {13'd1, 13'(v.kp)};
        ki_n  = {13'd0, 13'(v.ki)};
        kd_n  = {13'd0, 13'(v.kd)};
        kp_sh = {4'd0, 4'(v.kps)};
        ki_sh = {4'd0, 4'(v.kis)};
        kd_sh = {4'd0, 4'(v.kds)};
    endtask

    // Pulse start (optionally with clear) and count edges until done.
    task automatic do_run(input bit clr, output int lat);
        @(negedge clk);
        start = 1'b1;
        clear = clr;
        @(posedge clk);
        #1;
        start = 1'b0;
        clear = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int cnt;
        vec_t iv;

        tbl[0]  = '{1'b0,   100,    0,     3,  1, 0, 0, 0, 0,    90,    60,    60, 0};
        tbl[1]  = '{1'b1,    10,    0,     0,  0, 1, 0, 0, 0,    10,    10,    10, 0};
        tbl[2]  = '{1'b0,    10,    0,     0,  0, 1, 0, 0, 0,    20,    10,    20, 0};
        tbl[3]  = '{1'b0,    10,    0,     0,  0, 1, 0, 0, 0,    30,    10,    30, 0};
        tbl[4]  = '{1'b1,    10,    0,     0,  0, 1, 0, 0, 0,    10,    10,    10, 0};
        tbl[5]  = '{1'b1,    50,    0,     0,  0, 0, 0, 2, 0,   100,    50,    50, 0};
        tbl[6]  = '{1'b0,    20,    0,     0,  0, 0, 0, 2, 0,   -60,    20,    70, 0};
        tbl[7]  = '{1'b1,    -7,    0,     1,  1, 0, 0, 0, 0,    -4,    -7,    -7, 0};
        tbl[8]  = '{1'b1,  4000,    0,  4095,  0, 1, 0, 0, 0,  4095,  4000, (AW != 0) ? 0 : 2047, 1};
        tbl[9]  = '{1'b0,  4000,    0,  4095,  0, 1, 0, 0, 0,  4095,  4000, (AW != 0) ? 0 : 2047, 1};
        tbl[10] = '{1'b1, -4096, 4095,     1,  0, 0, 0, 0, 0, -4096, -4096, -2047, 0};
        tbl[11] = '{1'b0, -4096, 4095, -4096,  0, 0, 0, 0, 0,  4095, -4096, -2047, 0};
        tbl[12] = '{1'b1,  1000,    0,  4095, 15, 0, 0, 0, 0,   124,  1000,  1000, 0};
        tbl[13] = '{1'b1, -3000,    0,     2,  0, 1, 0, 0, 0, -4096, -3000, (AW != 0) ? 0 : -2047, 1};
        tbl[0].p = 40;

        // Reset state
        #12;
        check("reset_pwm", int'(pwm), 0);
        check("reset_err", int'(err), 0);
        check("reset_int", int'(int_err), 0);
        check("reset_dir", int'(dir), 3);
        check("reset_sat", int'(sat), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        vectors++;
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single runs
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            set_ch0(tbl[i]);
            do_run(tbl[i].clr, lat);
            check($sformatf("v%0d_latency", i), lat, 9);
            check($sformatf("v%0d_pwm0", i), chv(pwm, 0), tbl[i].x_pwm);
            check($sformatf("v%0d_err0", i), chv(err, 0), tbl[i].x_err);
            check($sformatf("v%0d_int0", i), chv(int_err, 0), tbl[i].x_int);
            check($sformatf("v%0d_dir0", i), int'(dir[0]), (tbl[i].x_pwm >= 0) ? 1 : 0);
            check($sformatf("v%0d_sat0", i), int'(sat[0]), tbl[i].x_sat);
            check($sformatf("v%0d_pwm1", i), chv(pwm, 1), -5);
            check($sformatf("v%0d_dir1", i), int'(dir[1]), 0);
            check($sformatf("v%0d_busy", i), int'(busy), 0);
            if (i == 0) begin
                @(posedge clk);
                #1;
                check("done_one_cycle", int'(done), 0);
            end
            vectors++;
        end

        // Integrator setup for the sequences below
        iv = '{1'b1, 10, 0, 0, 0, 1, 0, 0, 0, 10, 10, 10, 0};
        @(negedge clk);
        set_ch0(iv);
        do_run(1'b1, lat);
        check("seq_setup_int0", chv(int_err, 0), 10);
        vectors++;

        // Second start (with clear) while busy must be ignored
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) begin
                start = 1'b1;
                clear = 1'b1;
            end else begin
                start = 1'b0;
                clear = 1'b0;
            end
            if (done) cnt++;
        end
        check("busy_start_done_count", cnt, 1);
        check("busy_clear_ignored_int0", chv(int_err, 0), 20);
        check("busy_start_pwm0", chv(pwm, 0), 20);
        vectors++;

        // Reset asserted while channel 1 is in MUL
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_pwm", int'(pwm), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_int", int'(int_err), 0);
        check("midrst_dir", int'(dir), 3);
        check("midrst_sat", int'(sat), 0);
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        check("midrst_no_done", cnt, 0);
        do_run(1'b0, lat);
        check("post_rst_latency", lat, 9);
        check("post_rst_int0", chv(int_err, 0), 10);
        check("post_rst_pwm0", chv(pwm, 0), 10);
        check("post_rst_pwm1", chv(pwm, 1), -5);
        vectors++;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
